// File: rtl/instruction_fetch_ctrl_pkg.sv
// rtl/instruction_fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch controller
package instruction_fetch_ctrl_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_ctrl_if.sv
// rtl/instruction_fetch_ctrl_if.sv - memory, control and decode-side signals of the fetch controller
interface instruction_fetch_ctrl_if #(
  parameter int PC_W = 10
);
  import instruction_fetch_ctrl_pkg::*;

  logic [PC_W-1:0]    im_pc;
  logic [INSTR_W-1:0] im_instr;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_ready;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               halted;

  modport master (
    output im_pc,
    input  im_instr,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
    output halted
  );

  modport slave (
    input  im_pc,
    output im_instr,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  halted
  );

endinterface

// File: rtl/instruction_fetch_ctrl_fetch_out_reg.sv
// rtl/instruction_fetch_ctrl_fetch_out_reg.sv - valid/ready output stage holding the fetched instruction
module instruction_fetch_ctrl_fetch_out_reg
  import instruction_fetch_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               drop_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  // Flush only kills the valid bit; the stale payload is harmless behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// rtl/instruction_fetch_ctrl.sv - PC/FSM owner for the instruction memory; FETCH_STATS_EN adds fetch/redirect counters
module instruction_fetch_ctrl
  import instruction_fetch_ctrl_pkg::*;
#(
  parameter int                 PC_W       = 10,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_ctrl_if.master   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [15:0]                redirect_count
`endif
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            halted_q;
  logic            redir;
  logic            fire;
  logic            drop;
  logic [PC_W-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign redir           = bus.redirect_valid && (state_q != IDLE);
  assign redirect_target = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign unused_redirect_lsb = &{1'b0, bus.redirect_pc[1:0]};

  // Redirect outranks stall, and stall outranks both fetch and the decode-side bubble.
  assign fire = !redir && (state_q == RUN) && !bus.stall && (!bus.if_valid || bus.id_ready);
  assign drop = !redir && !fire && !bus.stall && bus.id_ready && bus.if_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (redir) begin
      state_q  <= RUN;
      pc_q     <= redirect_target;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: begin
          if (fire) begin
            pc_q <= pc_q + PC_W'(PC_STEP);
            if (bus.im_instr == HALT_INSTR) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: state_q <= HALTED;
        default: begin
          state_q  <= IDLE;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.im_pc  = pc_q;
  assign bus.halted = halted_q;

  instruction_fetch_ctrl_fetch_out_reg #(
    .PC_W (PC_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .load_i  (fire),
    .flush_i (redir),
    .drop_i  (drop),
    .instr_i (bus.im_instr),
    .pc_i    (pc_q),
    .valid_o (bus.if_valid),
    .instr_o (bus.if_instr),
    .pc_o    (bus.if_pc)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [15:0] redirect_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      if (fire && (fetch_count_q != '1)) fetch_count_q <= fetch_count_q + 32'd1;
      if (redir && (redirect_count_q != '1)) redirect_count_q <= redirect_count_q + 16'd1;
    end
  end

  assign fetch_count    = fetch_count_q;
  assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// tb/tb_instruction_fetch_ctrl.sv - directed scoreboard bench for instruction_fetch_ctrl
module tb_instruction_fetch_ctrl;
  import instruction_fetch_ctrl_pkg::*;

  localparam int PC_W = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_ctrl_if #(.PC_W(PC_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;
`endif

  instruction_fetch_ctrl #(
    .PC_W       (PC_W),
    .RESET_PC   ('0),
    .HALT_INSTR (HALT_INSTR_DEF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`endif
  );

  logic [31:0] mem [256];
  assign bus.im_instr = mem[bus.im_pc[PC_W-1:2]];

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a);
    exp_t e;
    e.pc    = a[PC_W-1:0];
    e.instr = mem[a >> 2];
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A transfer completes when valid&ready meet at the edge and neither a plain stall holds it.
  always @(negedge clk) begin
    if (!reset && bus.if_valid && bus.id_ready && (!bus.stall || bus.redirect_valid)) begin
      n_vec++;
      assert (sb.size() != 0)
      else begin
        n_err++;
        $error("FAIL sb_unexpected: observed transfer pc %0d expected none", bus.if_pc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("xfer_pc", 32'(bus.if_pc), 32'(mon_e.pc));
        chk("xfer_instr", bus.if_instr, mon_e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = HALT_INSTR_DEF;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;

    tick();
    chk("rst_im_pc", 32'(bus.im_pc), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    chk("rst_if_pc", 32'(bus.if_pc), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);

    push(0); push(4); push(8); push(12);
    reset = 1'b0;
    tick();
    chk("idle_im_pc", 32'(bus.im_pc), 32'd0);
    chk("idle_no_fetch", 32'(bus.if_valid), 32'd0);
    tick();
    chk("run_if_pc0", 32'(bus.if_pc), 32'd0);
    chk("run_if_instr0", bus.if_instr, 32'hC0DE_0000);
    chk("run_if_valid0", 32'(bus.if_valid), 32'd1);
    tick();
    chk("run_if_pc4", 32'(bus.if_pc), 32'd4);
    tick();
    chk("run_if_pc8", 32'(bus.if_pc), 32'd8);
    chk("run_im_pc12", 32'(bus.im_pc), 32'd12);

    bus.id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_if_pc", 32'(bus.if_pc), 32'd8);
      chk("bp_if_instr", bus.if_instr, 32'hC0DE_0002);
      chk("bp_im_pc", 32'(bus.im_pc), 32'd12);
      chk("bp_if_valid", 32'(bus.if_valid), 32'd1);
    end
    bus.id_ready = 1'b1;
    tick();
    chk("bp_release_pc", 32'(bus.if_pc), 32'd12);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd42;
    push(40);
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_flush", 32'(bus.if_valid), 32'd0);
    chk("redir_im_pc", 32'(bus.im_pc), 32'd40);
    tick();
    chk("redir_if_pc", 32'(bus.if_pc), 32'd40);
    chk("redir_if_valid", 32'(bus.if_valid), 32'd1);

    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd16;
    push(16); push(20);
    tick();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("stall_redir_im_pc", 32'(bus.im_pc), 32'd16);
    chk("stall_redir_flush", 32'(bus.if_valid), 32'd0);
    tick();
    chk("pre_halt_pc", 32'(bus.if_pc), 32'd16);
    tick();
    chk("halt_if_pc", 32'(bus.if_pc), 32'd20);
    chk("halt_if_instr", bus.if_instr, HALT_INSTR_DEF);
    chk("halt_if_valid", 32'(bus.if_valid), 32'd1);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_im_pc", 32'(bus.im_pc), 32'd24);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halted_no_valid", 32'(bus.if_valid), 32'd0);
      chk("halted_im_pc", 32'(bus.im_pc), 32'd24);
      chk("halted_hold", 32'(bus.halted), 32'd1);
    end

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd0;
    push(0);
    tick();
    bus.redirect_valid = 1'b0;
    chk("resume_im_pc", 32'(bus.im_pc), 32'd0);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    chk("resume_flush", 32'(bus.if_valid), 32'd0);
    tick();
    chk("resume_if_pc", 32'(bus.if_pc), 32'd0);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd1020;
    push(1020); push(0);
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_im_pc_top", 32'(bus.im_pc), 32'd1020);
    tick();
    chk("wrap_if_pc_top", 32'(bus.if_pc), 32'd1020);
    chk("wrap_im_pc_zero", 32'(bus.im_pc), 32'd0);
`ifdef FETCH_STATS_EN
    chk("stats_fetch_9", fetch_count, 32'd9);
`endif
    tick();
    chk("wrap_if_pc_zero", 32'(bus.if_pc), 32'd0);
    chk("wrap_im_pc_four", 32'(bus.im_pc), 32'd4);
`ifdef FETCH_STATS_EN
    chk("stats_fetch_10", fetch_count, 32'd10);
    chk("stats_redirect", 32'(redirect_count), 32'd4);
`endif

    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_im_pc", 32'(bus.im_pc), 32'd0);
    chk("midrst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("midrst_if_pc", 32'(bus.if_pc), 32'd0);
    chk("midrst_if_instr", bus.if_instr, 32'd0);
    chk("midrst_halted", 32'(bus.halted), 32'd0);
`ifdef FETCH_STATS_EN
    chk("midrst_fetch_count", fetch_count, 32'd0);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
